pipe_issue_ctrl: RTL and testbench
==================================

Name: pipe_issue_ctrl

Overview:
Issue/sequencing controller for the pipelined processor's ID->EX->WB path. It accepts one decoded instruction per cycle from the decode stage and drives the ALU control code into EX. It stalls issue on RAW hazards and on multi-cycle ALU ops, and generates the register-file write strobe and destination in WB. It replaces ad-hoc status gating of alu_control/write with an explicit valid-tracked pipeline.

Parameters:
REG_AW, 3, register address width (register 0 is hardwired zero)
FUNC_W, 2, ALU function code width
MC_LAT, 3, EX occupancy in cycles for multi-cycle func (2'b11); legal range 2..15

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
instr_valid  in  1  decode stage presents an instruction
instr_ready  out  1  controller accepts this cycle (issue = instr_valid & instr_ready)
id_func  in  FUNC_W  ALU function of presented instruction
id_rd  in  REG_AW  destination register (0 = no write)
id_rs1  in  REG_AW  source 1
id_rs2  in  REG_AW  source 2
id_uses_rs2  in  1  rs2 is a real operand
flush  in  1  kill ID and EX contents (branch redirect)
ex_valid  out  1  EX holds a live instruction
alu_control  out  FUNC_W  registered func for EX ALU
wb_write  out  1  register-file write enable, one cycle per instruction
wb_rd  out  REG_AW  register-file write address
stall  out  1  issue blocked by hazard or EX hold
busy  out  1  any of EX/WB valid

Behaviour:
- Reset (synchronous, active-high): ex_valid=0, alu_control=0, wb_write=0, wb_rd=0, EX FSM=EX_IDLE, counter=0. instr_ready=0 while reset is high. Reset mid-multi-cycle aborts the op; no wb_write is issued for it.
- Hazard: issue blocked if a used source (rs1; rs2 only if id_uses_rs2) is nonzero and equals a valid EX rd or a valid WB rd. rd=0 never creates a hazard and never asserts wb_write.
- ex_hold = EX FSM in EX_MC and counter != 1.
- stall = instr_valid & (hazard | ex_hold). instr_ready = ~reset & ~hazard & ~ex_hold (combinational).
- Latency, single-cycle func: issue at cycle N -> ex_valid/alu_control at N+1 -> wb_write/wb_rd at N+2.
- Multi-cycle func (2'b11): ex_valid held N+1..N+MC_LAT, alu_control stable throughout; wb_write at N+MC_LAT+1. Back-to-back issue is allowed on the final EX cycle.
- EX FSM:
  - EX_IDLE: on issue -> EX_RUN (func!=3) or EX_MC (counter=MC_LAT).
  - EX_RUN: on issue -> EX_RUN/EX_MC; else -> EX_IDLE.
  - EX_MC: counter decrements each cycle; at 1, behave as EX_RUN.
- WB register loads {valid, rd} from EX when EX retires. Otherwise it clears valid. wb_write = WB valid & (wb_rd!=0).
- flush: next cycle ex_valid=0 and FSM=EX_IDLE; any issue in the flush cycle is discarded. An instruction already in WB still writes. Flush has priority over stall and issue.
- Simultaneous hazard and flush: flush wins; instr_ready follows the hazard rule but the issue is dropped.
- alu_control holds its last value when ex_valid=0 (no X, no toggle).

Optional Feature:
FORWARD_EN
- Defined: the WB-stage match is not a hazard. Extra outputs fwd_rs1_wb and fwd_rs2_wb (1 bit each, registered into EX with the instruction) select the WB result as operand. An EX-stage match still stalls.
- Undefined: fwd_* ports are absent, and a WB match stalls one cycle.

Decomposition:
- Package pipe_ctrl_pkg: FUNC_W, REG_AW, FUNC_MC=2'b11, EX FSM state enum {EX_IDLE, EX_RUN, EX_MC}, MC counter width.
- One sub-module, pipe_hazard_cmp: combinational comparator of rs1/rs2 versus EX/WB rd with valids and uses_rs2. It outputs hazard (and fwd selects under FORWARD_EN).

Test Plan:
- Reset mid-op: issue func=2'b11, rd=3; assert reset on the second EX cycle -> next cycle ex_valid=0, busy=0, and wb_write is never asserted for rd=3.
- Back-to-back independent: issue rd=1 (func 0), then rd=2 (func 1) with rs1=5/6 -> instr_ready=1 both cycles; wb_write at N+2 (rd 1) and N+3 (rd 2).
- RAW on EX: issue rd=4, next instr rs1=4 -> stall=1 for 2 cycles without FORWARD_EN, 1 cycle with it; second issue then proceeds.
- Multi-cycle: MC_LAT=3, issue func=3, rd=2 -> ex_valid for 3 cycles with alu_control=3, stall during the first 2; wb_write, wb_rd=2 at N+4.
- rd=0 and unused rs2: issue rd=0, next rs2=0 with id_uses_rs2=0 -> no stall and no wb_write.
- Flush: issue rd=5, assert flush the next cycle together with a new issue -> EX cleared, no wb_write for either; an instruction in WB in the flush cycle still writes.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the ID->EX->WB issue controller: datapath widths,
// the multi-cycle ALU function code, the EX-stage FSM encoding and the
// width of the multi-cycle occupancy counter.
package pipe_ctrl_pkg;

  localparam int unsigned REG_AW   = 3;  // register address width, r0 hardwired zero
  localparam int unsigned FUNC_W   = 2;  // ALU function code width
  localparam int unsigned MC_CNT_W = 4;  // holds MC_LAT up to 15

  localparam logic [FUNC_W-1:0] FUNC_MC = 2'b11;

  typedef enum logic [1:0] {
    EX_IDLE = 2'd0,
    EX_RUN  = 2'd1,
    EX_MC   = 2'd2
  } ex_state_e;

endpackage

// File: rtl/pipe_hazard_cmp.sv
// Combinational RAW comparator: matches the presented instruction's used
// sources against the live EX and WB destinations. Register 0 never matches.
// With FORWARD_EN defined a WB match becomes a forward select instead of a
// hazard; an EX match always remains a hazard.
module pipe_hazard_cmp
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic              uses_rs2,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
`ifdef FORWARD_EN
  output logic              fwd_rs1_wb,
  output logic              fwd_rs2_wb,
`endif
  output logic              hazard
);

  logic ex_m1, ex_m2, wb_m1, wb_m2;

  // Per-source, per-stage match terms and the resulting hazard.
  always_comb begin
    ex_m1  = (rs1 != '0) && ex_valid && (rs1 == ex_rd);
    ex_m2  = uses_rs2 && (rs2 != '0) && ex_valid && (rs2 == ex_rd);
    wb_m1  = (rs1 != '0) && wb_valid && (rs1 == wb_rd);
    wb_m2  = uses_rs2 && (rs2 != '0) && wb_valid && (rs2 == wb_rd);
`ifdef FORWARD_EN
    hazard     = ex_m1 | ex_m2;
    fwd_rs1_wb = wb_m1;
    fwd_rs2_wb = wb_m2;
`else
    hazard     = ex_m1 | ex_m2 | wb_m1 | wb_m2;
`endif
  end

endmodule

// File: rtl/pipe_issue_ctrl.sv
// Issue/sequencing controller for the ID->EX->WB path. Accepts one decoded
// instruction per cycle, stalls on RAW hazards and while a multi-cycle ALU op
// occupies EX, and produces the WB register-file write strobe.
// Optional feature macro: FORWARD_EN (WB-stage operand forwarding; adds the
// fwd_rs1_wb / fwd_rs2_wb outputs). Widths come from pipe_ctrl_pkg.
module pipe_issue_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MC_LAT = 3  // EX occupancy of FUNC_MC, legal 2..15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [FUNC_W-1:0] id_func,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs2,
  input  logic              flush,
  output logic              ex_valid,
  output logic [FUNC_W-1:0] alu_control,
  output logic              wb_write,
  output logic [REG_AW-1:0] wb_rd,
  output logic              stall,
`ifdef FORWARD_EN
  output logic              fwd_rs1_wb,
  output logic              fwd_rs2_wb,
`endif
  output logic              busy
);

  localparam logic [MC_CNT_W-1:0] McLoad = MC_CNT_W'(MC_LAT);
  localparam logic [MC_CNT_W-1:0] CntOne = MC_CNT_W'(1);

  ex_state_e           state_q, state_d;
  logic [MC_CNT_W-1:0] cnt_q, cnt_d;

  logic              ex_valid_q;
  logic [REG_AW-1:0] ex_rd_q;
  logic [FUNC_W-1:0] alu_q;
  logic              wb_valid_q;
  logic [REG_AW-1:0] wb_rd_q;

  logic hazard, ex_hold, issue, ex_retire;

`ifdef FORWARD_EN
  logic fwd1_c, fwd2_c, fwd1_q, fwd2_q;
`endif

  pipe_hazard_cmp u_hazard (
    .rs1        (id_rs1),
    .rs2        (id_rs2),
    .uses_rs2   (id_uses_rs2),
    .ex_valid   (ex_valid_q),
    .ex_rd      (ex_rd_q),
    .wb_valid   (wb_valid_q),
    .wb_rd      (wb_rd_q),
`ifdef FORWARD_EN
    .fwd_rs1_wb (fwd1_c),
    .fwd_rs2_wb (fwd2_c),
`endif
    .hazard     (hazard)
  );

  // EX FSM state and multi-cycle counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EX_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // EX FSM next state; the last MC cycle accepts a new issue like EX_RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = EX_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        EX_MC: begin
          if (cnt_q != CntOne) begin
            cnt_d = cnt_q - CntOne;
          end else if (issue) begin
            state_d = (id_func == FUNC_MC) ? EX_MC : EX_RUN;
            cnt_d   = (id_func == FUNC_MC) ? McLoad : '0;
          end else begin
            state_d = EX_IDLE;
            cnt_d   = '0;
          end
        end
        EX_IDLE, EX_RUN: begin
          if (issue) begin
            state_d = (id_func == FUNC_MC) ? EX_MC : EX_RUN;
            cnt_d   = (id_func == FUNC_MC) ? McLoad : '0;
          end else begin
            state_d = EX_IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = EX_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Handshake, stall and retire decode from current state.
  always_comb begin
    ex_hold     = (state_q == EX_MC) && (cnt_q != CntOne);
    instr_ready = ~reset & ~hazard & ~ex_hold;
    stall       = instr_valid & (hazard | ex_hold);
    // A flush discards the issue and the EX instruction before it reaches WB.
    issue       = instr_valid & instr_ready & ~flush;
    ex_retire   = ex_valid_q & ~ex_hold & ~flush;
  end

  // EX and WB pipeline registers; alu_control only moves on issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q <= 1'b0;
      ex_rd_q    <= '0;
      alu_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
    end else begin
      ex_valid_q <= ~flush & (issue | ex_hold);
      if (issue) begin
        ex_rd_q <= id_rd;
        alu_q   <= id_func;
      end
      wb_valid_q <= ex_retire;
      if (ex_retire) begin
        wb_rd_q <= ex_rd_q;
      end
    end
  end

`ifdef FORWARD_EN
  // Forward selects travel into EX with the instruction they belong to.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      fwd1_q <= 1'b0;
      fwd2_q <= 1'b0;
    end else if (issue) begin
      fwd1_q <= fwd1_c;
      fwd2_q <= fwd2_c;
    end else if (!ex_hold) begin
      fwd1_q <= 1'b0;
      fwd2_q <= 1'b0;
    end
  end

  assign fwd_rs1_wb = fwd1_q;
  assign fwd_rs2_wb = fwd2_q;
`endif

  assign ex_valid    = ex_valid_q;
  assign alu_control = alu_q;
  assign wb_write    = wb_valid_q & (wb_rd_q != '0);
  assign wb_rd       = wb_rd_q;
  assign busy        = ex_valid_q | wb_valid_q;

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Directed bench for pipe_issue_ctrl: a per-cycle vector table with
// hand-computed expectations plus short sequences for multi-cycle corners.
module tb_pipe_issue_ctrl;

  localparam int unsigned MC_LAT = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid;
  logic       instr_ready;
  logic [1:0] id_func;
  logic [2:0] id_rd, id_rs1, id_rs2;
  logic       id_uses_rs2;
  logic       flush;
  logic       ex_valid;
  logic [1:0] alu_control;
  logic       wb_write;
  logic [2:0] wb_rd;
  logic       stall;
  logic       busy;
`ifdef FORWARD_EN
  logic       fwd_rs1_wb, fwd_rs2_wb;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_issue_ctrl #(.MC_LAT(MC_LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .id_func     (id_func),
    .id_rd       (id_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs2 (id_uses_rs2),
    .flush       (flush),
    .ex_valid    (ex_valid),
    .alu_control (alu_control),
    .wb_write    (wb_write),
    .wb_rd       (wb_rd),
    .stall       (stall),
`ifdef FORWARD_EN
    .fwd_rs1_wb  (fwd_rs1_wb),
    .fwd_rs2_wb  (fwd_rs2_wb),
`endif
    .busy        (busy)
  );

  typedef struct {
    bit       rst, iv, u2, fl;
    bit [1:0] f;
    bit [2:0] rd, rs1, rs2;
    bit       rdy, stl, exv, wbw, bsy;
    bit [1:0] alu;
    bit [2:0] wbrd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, bit iv, bit [1:0] f, bit [2:0] rd, bit [2:0] rs1,
                              bit [2:0] rs2, bit u2, bit fl, bit rdy, bit stl, bit exv,
                              bit [1:0] alu, bit wbw, bit [2:0] wbrd, bit bsy);
    vec_t v;
    v.rst = rst; v.iv = iv; v.f = f; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.u2 = u2;
    v.fl = fl; v.rdy = rdy; v.stl = stl; v.exv = exv; v.alu = alu; v.wbw = wbw;
    v.wbrd = wbrd; v.bsy = bsy;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit rst, input bit iv, input bit [1:0] f, input bit [2:0] rd,
                       input bit [2:0] rs1, input bit [2:0] rs2, input bit u2, input bit fl);
    reset = rst; instr_valid = iv; id_func = f; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_uses_rs2 = u2; flush = fl;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int  k;
    int  exv_cnt;
    int  wbw_cnt;
    bit  found;

    drive(1, 0, 0, 0, 0, 0, 0, 0);

    //            rst iv f  rd rs1 rs2 u2 fl | rdy stl exv alu wbw wbrd bsy
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0)); // ready low in reset
    // back-to-back independent
    vecs.push_back(mk(0, 1, 0, 1, 5, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 2, 6, 0, 0, 0,  1, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 1, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 1, 2, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 2, 0));
    // RAW on EX rd=4
    vecs.push_back(mk(0, 1, 2, 4, 1, 0, 0, 0,  1, 0, 0, 1, 0, 2, 0));
    vecs.push_back(mk(0, 1, 0, 6, 4, 0, 0, 0,  0, 1, 1, 2, 0, 2, 1));
`ifdef FORWARD_EN
    vecs.push_back(mk(0, 1, 0, 6, 4, 0, 0, 0,  1, 0, 0, 2, 1, 4, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 4, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 6, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 6, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 6, 0));
`else
    vecs.push_back(mk(0, 1, 0, 6, 4, 0, 0, 0,  0, 1, 0, 2, 1, 4, 1));
    vecs.push_back(mk(0, 1, 0, 6, 4, 0, 0, 0,  1, 0, 0, 2, 0, 4, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 4, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 6, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 6, 0));
`endif
    // rd=0, unused rs2, then a real rs2 hazard
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 6, 0));
    vecs.push_back(mk(0, 1, 0, 3, 7, 0, 0, 0,  1, 0, 1, 1, 0, 6, 1));
    vecs.push_back(mk(0, 1, 0, 1, 0, 3, 0, 0,  1, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 2, 0, 1, 1, 0,  0, 1, 1, 0, 1, 3, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 1, 0));
    // multi-cycle rd=2 with a waiting successor rd=5
    vecs.push_back(mk(0, 1, 3, 2, 0, 0, 0, 0,  1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 5, 0, 0, 0, 0,  0, 1, 1, 3, 0, 1, 1));
    vecs.push_back(mk(0, 1, 0, 5, 0, 0, 0, 0,  0, 1, 1, 3, 0, 1, 1));
    vecs.push_back(mk(0, 1, 0, 5, 0, 0, 0, 0,  1, 0, 1, 3, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 1, 2, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 5, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 5, 0));
    // flush with rd=7 in WB, rd=5 in EX, rd=6 issuing
    vecs.push_back(mk(0, 1, 2, 7, 0, 0, 0, 0,  1, 0, 0, 0, 0, 5, 0));
    vecs.push_back(mk(0, 1, 1, 5, 0, 0, 0, 0,  1, 0, 1, 2, 0, 5, 1));
    vecs.push_back(mk(0, 1, 0, 6, 0, 0, 0, 1,  1, 0, 1, 1, 1, 7, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 7, 0));
    // flush together with a hazard
    vecs.push_back(mk(0, 1, 0, 4, 0, 0, 0, 0,  1, 0, 0, 1, 0, 7, 0));
    vecs.push_back(mk(0, 1, 3, 2, 4, 0, 0, 1,  0, 1, 1, 0, 0, 7, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 7, 0));
    // reset on the second EX cycle of a multi-cycle rd=3
    vecs.push_back(mk(0, 1, 3, 3, 0, 0, 0, 0,  1, 0, 0, 0, 0, 7, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 3, 0, 7, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 3, 0, 7, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0));

    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      drive(vecs[i].rst, vecs[i].iv, vecs[i].f, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
            vecs[i].u2, vecs[i].fl);
      @(negedge clk);
      check($sformatf("v%0d instr_ready", i), int'(instr_ready), int'(vecs[i].rdy));
      check($sformatf("v%0d stall", i),       int'(stall),       int'(vecs[i].stl));
      check($sformatf("v%0d ex_valid", i),    int'(ex_valid),    int'(vecs[i].exv));
      check($sformatf("v%0d alu_control", i), int'(alu_control), int'(vecs[i].alu));
      check($sformatf("v%0d wb_write", i),    int'(wb_write),    int'(vecs[i].wbw));
      check($sformatf("v%0d wb_rd", i),       int'(wb_rd),       int'(vecs[i].wbrd));
      check($sformatf("v%0d busy", i),        int'(busy),        int'(vecs[i].bsy));
    end

    // Multi-cycle latency measured against MC_LAT, bounded wait on wb_write.
    @(posedge clk); #1;
    drive(0, 1, 3, 6, 0, 0, 0, 0);
    @(negedge clk);
    check("mc_issue_ready", int'(instr_ready), 1);
    exv_cnt = 0;
    found   = 1'b0;
    k       = 0;
    while (!found && k < 20) begin
      idle_cycle();
      k++;
      @(negedge clk);
      if (ex_valid) begin
        exv_cnt++;
        check("mc_alu_stable", int'(alu_control), 3);
      end
      if (wb_write) found = 1'b1;
    end
    check("mc_wb_seen", int'(found), 1);
    check("mc_wb_latency", k, MC_LAT + 1);
    check("mc_ex_cycles", exv_cnt, MC_LAT);
    check("mc_wb_rd", int'(wb_rd), 6);
    idle_cycle();
    idle_cycle();

    // Flush on the second EX cycle of a multi-cycle op aborts it.
    @(posedge clk); #1;
    drive(0, 1, 3, 1, 0, 0, 0, 0);
    idle_cycle();
    @(posedge clk); #1;
    drive(0, 1, 0, 2, 0, 0, 0, 1);
    @(negedge clk);
    check("mcflush_stall", int'(stall), 1);
    check("mcflush_ready", int'(instr_ready), 0);
    idle_cycle();
    @(negedge clk);
    check("mcflush_ex_valid", int'(ex_valid), 0);
    check("mcflush_busy", int'(busy), 0);
    check("mcflush_alu_hold", int'(alu_control), 3);
    wbw_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      idle_cycle();
      @(negedge clk);
      if (wb_write) wbw_cnt++;
    end
    check("mcflush_no_wb", wbw_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
